// File: rtl/regfile_pkg.sv
// Shared widths and types for the 32 x 64 register file.
// Optional same-cycle write forwarding is enabled by REGFILE_WRITE_BYPASS_EN.
package regfile_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int ZERO_REG   = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);
endpackage

// File: rtl/register_file_64x32_if.sv
// Register-file bus: two read selects with their data, plus one write port.
// Combinational reads: A/B follow SA/SB within the same cycle; a write (W=1) commits on the next rising edge.
interface register_file_64x32_if;
  import regfile_pkg::*;

  reg_addr_t SA;
  reg_addr_t SB;
  reg_addr_t DA;
  logic      W;
  reg_data_t D;
  reg_data_t A;
  reg_data_t B;

  modport master (output SA, SB, DA, W, D, input A, B);
  modport slave  (input SA, SB, DA, W, D, output A, B);
endinterface

// File: rtl/regfile_cell.sv
// One DATA_WIDTH storage register with synchronous active-high clear and load enable.
module regfile_cell
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      en,
  input  reg_data_t d,
  output reg_data_t q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_64x32.sv
// 32 x 64 register file, two combinational read ports, one write port; X31 reads zero.
// Define REGFILE_WRITE_BYPASS_EN to forward D to a read port that selects the register being written.
module register_file_64x32
  import regfile_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  register_file_64x32_if.slave   bus
);

  reg_data_t rf [NUM_REGS];
  reg_data_t rd_a;
  reg_data_t rd_b;

  // The zero register has no storage; writes to it never reach a cell.
  assign rf[ZERO_REG] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < ZERO_REG; gi++) begin : g_cell
      logic en;
      assign en = bus.W & (bus.DA == reg_addr_t'(gi));
      regfile_cell u_cell (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .d     (bus.D),
        .q     (rf[gi])
      );
    end
  endgenerate

  assign rd_a = rf[bus.SA];
  assign rd_b = rf[bus.SB];

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_live;
  assign wr_live = bus.W & ~reset & (bus.DA != ZERO_ADDR);

  always_comb begin
    bus.A = rd_a;
    bus.B = rd_b;
    if (wr_live && (bus.DA == bus.SA)) bus.A = bus.D;
    if (wr_live && (bus.DA == bus.SB)) bus.B = bus.D;
  end
`else
  always_comb begin
    bus.A = rd_a;
    bus.B = rd_b;
  end
`endif

endmodule

// File: tb/tb_register_file_64x32.sv
// Bench for register_file_64x32: directed cases with literal expectations plus a random run,
// all cross-checked every cycle against an array model of the register file.
module tb_register_file_64x32;
  logic clock;
  logic reset;
  register_file_64x32_if bus ();

  register_file_64x32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] model [32];
  logic [63:0] exp_q [$];
  bit model_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] sel);
    if (sel == 5'd31) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (bus.W && !reset && bus.DA == sel) return bus.D;
`endif
    return model[sel];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
      model_valid = 1'b1;
    end else if (bus.W && bus.DA != 5'd31) begin
      model[bus.DA] = bus.D;
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_a", bus.A, model_read(bus.SA));
      check("model_b", bus.B, model_read(bus.SB));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [63:0] data);
    bus.W = 1'b1; bus.DA = addr; bus.D = data;
    step();
    bus.W = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [4:0] sa, input logic [4:0] sb,
                          input logic [63:0] ea, input logic [63:0] eb);
    bus.SA = sa; bus.SB = sb;
    @(negedge clock);
    check({name, "_a"}, bus.A, ea);
    check({name, "_b"}, bus.B, eb);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.SA = '0; bus.SB = '0; bus.DA = '0; bus.W = 1'b0; bus.D = '0;
    step(); step();
    reset = 1'b0;

    // Reset clears a written value and every entry.
    wr(5'd5, 64'hDEAD);
    rd_check("x5_written", 5'd5, 5'd5, 64'hDEAD, 64'hDEAD);
    reset = 1'b1; step(); reset = 1'b0;
    rd_check("x5_after_reset", 5'd5, 5'd31, 64'd0, 64'd0);
    for (int i = 0; i < 32; i++)
      rd_check("reset_all", 5'(i), 5'(31 - i), 64'd0, 64'd0);

    // Basic write/read feeding ALU add.
    wr(5'd3, 64'hD);
    wr(5'd4, 64'h6);
    rd_check("x3_x4", 5'd3, 5'd4, 64'hD, 64'h6);
    check("alu_add", bus.A + bus.B, 64'h13);

    // Zero register ignores writes.
    wr(5'd31, '1);
    rd_check("xzr", 5'd31, 5'd31, 64'd0, 64'd0);

    // Reset beats a same-edge write.
    reset = 1'b1; bus.W = 1'b1; bus.DA = 5'd7; bus.D = 64'h55;
    step();
    reset = 1'b0; bus.W = 1'b0;
    rd_check("reset_vs_write", 5'd7, 5'd7, 64'd0, 64'd0);

    // Read during write.
    wr(5'd9, 64'h1);
    bus.W = 1'b1; bus.DA = 5'd9; bus.D = 64'h2; bus.SA = 5'd9; bus.SB = 5'd9;
    @(negedge clock);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before_a", bus.A, 64'h2);
    check("rdw_before_b", bus.B, 64'h2);
`else
    check("rdw_before_a", bus.A, 64'h1);
    check("rdw_before_b", bus.B, 64'h1);
`endif
    step();
    bus.W = 1'b0;
    rd_check("rdw_after", 5'd9, 5'd9, 64'h2, 64'h2);

    // Sweep all storage entries through both ports.
    for (int i = 0; i < 31; i++) begin
      wr(5'(i), 64'(i) * 64'h0101);
      exp_q.push_back(64'(i) * 64'h0101);
    end
    for (int i = 0; i < 31; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      exp_q.push_back(e);
      rd_check("sweep", 5'(i), 5'(i), e, e);
    end
    for (int i = 0; i < 8; i++) begin
      bus.W = 1'b0; bus.DA = 5'($urandom_range(0, 31)); bus.D = {$urandom, $urandom};
      step();
    end
    for (int i = 0; i < 31; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      rd_check("hold", 5'(i), 5'(30 - i), e, 64'(30 - i) * 64'h0101);
    end

    // Random traffic; the per-cycle compare process checks it.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      bus.W  = $urandom_range(0, 1);
      bus.DA = 5'($urandom_range(0, 31));
      bus.D  = {$urandom, $urandom};
      bus.SA = ($urandom_range(0, 3) == 0) ? bus.DA : 5'($urandom_range(0, 31));
      bus.SB = 5'($urandom_range(0, 31));
      step();
    end
    reset = 1'b0; bus.W = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
